// File: rtl/irq_pkg.sv
// Shared types and helpers for the irq_ctrl interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int IRQ_N_MAX = 16;

    function automatic int irq_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Rising-edge detector feeding a sticky pending register; a new edge beats a clear.
module irq_edge_capture #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_irq,
    input  logic [N-1:0] i_clr,
    output logic [N-1:0] o_pending
);

    logic [N-1:0] r_prev;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_rise;

    assign w_rise    = i_irq & ~r_prev;
    assign o_pending = r_pending;

    // Previous-sample register and pending set/clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_irq;
            r_pending <= (r_pending & ~i_clr) | w_rise;
        end
    end

endmodule

// File: rtl/irq_prio_enc.sv
// N-input priority encoder; highest set index wins, o_valid flags a nonzero vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter  int N    = 8,
    localparam int ID_W = irq_id_w(N)
) (
    input  logic [N-1:0]    i_vec,
    output logic [ID_W-1:0] o_id,
    output logic            o_valid
);

    // Ascending scan so the last (highest) set bit overrides lower ones
    always_comb begin
        o_id    = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_id    = ID_W'(i);
                o_valid = 1'b1;
            end else begin
                o_id    = o_id;
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture, enable mask, priority select and a
// request/ack/done handshake that presents one interrupt at a time.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter  int N    = 8,
    localparam int ID_W = irq_id_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq_in,
    input  logic            mask_we,
    input  logic [N-1:0]    mask_wdata,
    input  logic [N-1:0]    pend_clr,
    input  logic            irq_ack,
    input  logic            irq_done,
    output logic            irq_req,
    output logic [ID_W-1:0] irq_id,
    output logic            in_service,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    mask
);

    irq_state_e      r_state;
    irq_state_e      w_state_next;
    logic [ID_W-1:0] r_irq_id;
    logic [ID_W-1:0] w_irq_id_next;
    logic            r_irq_req;
    logic            r_in_service;
    logic [N-1:0]    r_mask;
    logic [N-1:0]    w_pending;
    logic [N-1:0]    w_masked;
    logic [N-1:0]    w_ack_clr;
    logic [N-1:0]    w_clr;
    logic [ID_W-1:0] w_enc_id;
    logic            w_enc_valid;

    assign w_masked = w_pending & r_mask;
    assign w_clr    = pend_clr | w_ack_clr;

    irq_edge_capture #(.N(N)) u_edge (
        .clk       (clk),
        .rst       (rst),
        .i_irq     (irq_in),
        .i_clr     (w_clr),
        .o_pending (w_pending)
    );

    irq_prio_enc #(.N(N)) u_enc (
        .i_vec   (w_masked),
        .o_id    (w_enc_id),
        .o_valid (w_enc_valid)
    );

    // Next-state logic; the presented id is frozen from REQ until back in IDLE
    always_comb begin
        w_state_next  = r_state;
        w_irq_id_next = r_irq_id;
        w_ack_clr     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_valid) begin
                    w_state_next  = ST_REQ;
                    w_irq_id_next = w_enc_id;
                end else begin
                    w_state_next  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_next = ST_SERVICE;
                    w_ack_clr    = {{(N-1){1'b0}}, 1'b1} << r_irq_id;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SERVICE;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_irq_id_next = '0;
            end
        endcase
    end

    // State, id, mask and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_irq_id     <= '0;
            r_irq_req    <= 1'b0;
            r_in_service <= 1'b0;
            r_mask       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_irq_id     <= w_irq_id_next;
            r_irq_req    <= (w_state_next == ST_REQ);
            r_in_service <= (w_state_next == ST_SERVICE);
            r_mask       <= mask_we ? mask_wdata : r_mask;
        end
    end

    assign irq_req    = r_irq_req;
    assign irq_id     = r_irq_id;
    assign in_service = r_in_service;
    assign pending    = w_pending;
    assign mask       = r_mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl (N=8): behavioural model predicts every cycle's outputs.
module tb_irq_ctrl;

    localparam int N = 8;

    typedef struct packed {
        logic       req;
        logic [2:0] id;
        logic       svc;
        logic [7:0] pend;
        logic [7:0] msk;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_in = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic [7:0] pend_clr = 8'h00;
    logic       irq_ack = 1'b0;
    logic       irq_done = 1'b0;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] mask;

    int errors = 0;
    int checks = 0;
    int req_rises = 0;
    logic prev_req = 1'b0;
    snap_t exp_q[$];

    // Behavioural model state: mode 0=idle, 1=requesting, 2=in service
    int         m_mode = 0;
    int         m_id = 0;
    bit [7:0]   m_pend = 8'h00;
    bit [7:0]   m_mask = 8'h00;
    bit [7:0]   m_prev = 8'h00;

    irq_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .pend_clr(pend_clr), .irq_ack(irq_ack),
        .irq_done(irq_done), .irq_req(irq_req), .irq_id(irq_id),
        .in_service(in_service), .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit [7:0] clr;
        bit [7:0] cand;
        clr = pend_clr;
        if (rst) begin
            m_mode = 0; m_id = 0; m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
        end else begin
            cand = m_pend & m_mask;
            if (m_mode == 0 && cand != 8'h00) begin
                for (int i = 0; i < N; i++) if (cand[i]) m_id = i;
                m_mode = 1;
            end else if (m_mode == 1 && irq_ack) begin
                clr[m_id] = 1'b1;
                m_mode = 2;
            end else if (m_mode == 2 && irq_done) begin
                m_mode = 0;
            end
            m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
            if (mask_we) m_mask = mask_wdata;
            m_prev = irq_in;
        end
    endtask

    // One clock: predict, queue the expectation, then release one-cycle pulses
    task automatic tick();
        snap_t e;
        model_step();
        e.req  = (m_mode == 1);
        e.id   = 3'(m_id);
        e.svc  = (m_mode == 2);
        e.pend = m_pend;
        e.msk  = m_mask;
        exp_q.push_back(e);
        @(negedge clk);
        mask_we = 1'b0; pend_clr = 8'h00; irq_ack = 1'b0; irq_done = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic serve();
        int n;
        n = 0;
        while (m_mode != 1 && n < 10) begin tick(); n++; end
        chk("serve_reached_req", m_mode, 1);
        irq_ack = 1'b1; tick();
        tick();
        irq_done = 1'b1; tick();
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle
    always @(posedge clk) begin
        snap_t e;
        snap_t a;
        #1;
        if (irq_req && !prev_req) req_rises++;
        prev_req = irq_req;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{req: irq_req, id: irq_id, svc: in_service, pend: pending, msk: mask};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_snapshot t=%0t got req=%b id=%0d svc=%b pend=%h mask=%h expected req=%b id=%0d svc=%b pend=%h mask=%h",
                         $time, a.req, a.id, a.svc, a.pend, a.msk, e.req, e.id, e.svc, e.pend, e.msk);
            end
        end
    end

    initial begin
        int r0;
        @(negedge clk);
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        chk("reset_req", int'(irq_req), 0);
        chk("reset_pending", int'(pending), 0);

        // Basic request / ack / done
        mask_we = 1'b1; mask_wdata = 8'hFF; tick();
        irq_in = 8'h08; tick();
        chk("edge_to_pending", int'(pending), 8'h08);
        irq_in = 8'h00; tick();
        chk("pending_to_req", int'(irq_req), 1);
        chk("req_id3", int'(irq_id), 3);
        tick();
        irq_ack = 1'b1; tick();
        chk("ack_in_service", int'(in_service), 1);
        chk("ack_clears_pending", int'(pending), 0);
        tick();
        irq_done = 1'b1; tick();
        tick(); tick();
        chk("done_no_req", int'(irq_req), 0);

        // Priority among simultaneous edges
        irq_in = 8'h52; tick();
        irq_in = 8'h00; tick();
        chk("prio_id6", int'(irq_id), 6);
        serve();
        serve();
        serve();

        // Masked bits accumulate but do not request
        mask_we = 1'b1; mask_wdata = 8'h01; tick();
        irq_in = 8'h20; tick();
        irq_in = 8'h00; tick(); tick(); tick();
        chk("masked_no_req", int'(irq_req), 0);
        mask_we = 1'b1; mask_wdata = 8'h20; tick();
        tick();
        chk("unmask_req_id5", int'(irq_id), 5);
        chk("unmask_req", int'(irq_req), 1);
        serve();

        // New edge on the presented bit coinciding with ack
        mask_we = 1'b1; mask_wdata = 8'hFF; tick();
        irq_in = 8'h04; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h04; irq_ack = 1'b1; tick();
        chk("set_wins_over_ack", int'(pending[2]), 1);
        irq_in = 8'h00; irq_done = 1'b1; tick();
        tick();
        chk("rerequest_id2", int'(irq_id), 2);
        serve();

        // Held level gives one request; stray ack/done are ignored
        pend_clr = 8'hFF; tick();
        r0 = req_rises;
        irq_in = 8'h01;
        for (int i = 0; i < 20; i++) begin
            irq_ack = (m_mode == 1); irq_done = (m_mode == 2); tick();
        end
        tick();
        chk("held_level_one_req", req_rises - r0, 1);
        irq_ack = 1'b1; tick();
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick();
        irq_done = 1'b1; tick();
        chk("stray_done_in_req", int'(irq_req), 1);
        serve();

        // Reset in service
        irq_in = 8'h81; tick();
        irq_in = 8'h00; tick();
        irq_ack = 1'b1; tick();
        irq_in = 8'h80; tick();
        chk("pending_81", int'(pending), 8'h81);
        irq_in = 8'h00; rst = 1'b1; tick();
        chk("rst_all_zero", int'({irq_req, irq_id, in_service, pending, mask}), 0);
        rst = 1'b0; mask_we = 1'b1; mask_wdata = 8'hFF; tick();
        for (int i = 0; i < 5; i++) tick();
        chk("no_req_after_rst", int'(irq_req), 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 8'($urandom);
            pend_clr   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            irq_ack    = ($urandom_range(0, 2) == 0);
            irq_done   = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
